// File: rtl/niosii_processor_pb_edge.sv
// Pushbutton edge-capture Avalon-MM slave: synchronises and debounces active-low
// buttons, latches presses in EDGECAP and raises a maskable level interrupt.
`timescale 1ns/1ps
module niosii_processor_pb_edge #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1, sync2, stable;
  logic [WIDTH-1:0] irq_mask, edge_cap;
  logic [WIDTH-1:0] accept, press, clear;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // A bit is accepted on the edge its counter has already seen DEBOUNCE_CYCLES-1 differing samples.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
    end
  end

  assign press = accept & stable;
  assign clear = (wr_en && address == 2'd3) ? wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '1;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
        if (accept[i]) begin
          stable[i] <= sync2[i];
        end
      end
    end
  end

  // Set has priority over a same-edge write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
      irq_mask <= '0;
    end else begin
      edge_cap <= (edge_cap & ~clear) | press;
      if (wr_en && address == 2'd2) begin
        irq_mask <= wdata;
      end
    end
  end

  assign irq = |(edge_cap & irq_mask);

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = stable;
      2'd2:    readdata[WIDTH-1:0] = irq_mask;
      2'd3:    readdata[WIDTH-1:0] = edge_cap;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_niosii_processor_pb_edge.sv
// Self-checking bench for niosii_processor_pb_edge: directed scenarios with literal
// expectations followed by randomized traffic compared against a behavioural model.
`timescale 1ns/1ps
module tb_niosii_processor_pb_edge;

  localparam int W = 4;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   readdata;
  logic          irq;

  int n_cmp = 0;
  int n_bad = 0;

  niosii_processor_pb_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #10 clk = ~clk;

  // Model: pins pass a two-stage delay; a bit flips once its last D delayed samples all differ from it.
  logic [W-1:0] m_p1, m_p2, m_stable, m_mask, m_cap;
  logic [W-1:0] hist[$];

  task automatic model_reset();
    m_p1 = '1; m_p2 = '1; m_stable = '1; m_mask = '0; m_cap = '0;
    hist.delete();
  endtask

  task automatic model_step();
    logic [W-1:0] old_s, press, clr;
    bit all_diff;
    if (!reset_n) begin
      model_reset();
      return;
    end
    old_s = m_stable;
    press = '0;
    hist.push_back(m_p2);
    if (hist.size() > D) void'(hist.pop_front());
    for (int i = 0; i < W; i++) begin
      if (hist.size() == D) begin
        all_diff = 1'b1;
        for (int k = 0; k < D; k++) if (hist[k][i] == old_s[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_stable[i] = ~old_s[i];
          press[i] = old_s[i];
        end
      end
    end
    clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
    m_cap = (m_cap & ~clr) | press;
    m_p2 = m_p1;
    m_p1 = in_port;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_stable);
      2'd2:    return 32'(m_mask);
      2'd3:    return 32'(m_cap);
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    check_output("model_readdata", readdata, model_read(address));
    check_output("model_irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic apply_stimulus(input int n);
    repeat (n) tick();
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic expect_reg(input logic [1:0] a, input logic [31:0] exp, input string name);
    address = a;
    #1;
    check_output(name, readdata, exp);
  endtask

  task automatic do_reset(input logic [W-1:0] pins);
    reset_n = 1'b0;
    in_port = pins;
    apply_stimulus(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    model_reset();
    @(negedge clk);

    // Reset with buttons held pressed, then release
    do_reset(4'h0);
    expect_reg(2'd0, 32'hF, "rst_data");
    expect_reg(2'd2, 32'h0, "rst_mask");
    expect_reg(2'd3, 32'h0, "rst_cap");
    check_output("rst_irq", {31'd0, irq}, 32'd0);
    apply_stimulus(5);
    expect_reg(2'd0, 32'hF, "rst_data_5");
    apply_stimulus(1);
    expect_reg(2'd0, 32'h0, "rst_data_6");
    expect_reg(2'd3, 32'hF, "rst_cap_6");

    // Clean press on bit 0
    do_reset(4'hF);
    do_write(2'd2, 32'h1);
    in_port = 4'hE;
    apply_stimulus(5);
    expect_reg(2'd0, 32'hF, "press_data_5");
    check_output("press_irq_5", {31'd0, irq}, 32'd0);
    apply_stimulus(1);
    expect_reg(2'd0, 32'hE, "press_data_6");
    expect_reg(2'd3, 32'h1, "press_cap_6");
    check_output("press_irq_6", {31'd0, irq}, 32'd1);
    in_port = 4'hF;
    apply_stimulus(8);
    expect_reg(2'd3, 32'h1, "release_cap");
    expect_reg(2'd0, 32'hF, "release_data");

    // Glitch rejection on bit 1
    do_write(2'd3, 32'hF);
    in_port = 4'hD; apply_stimulus(3);
    in_port = 4'hF; apply_stimulus(1);
    in_port = 4'hD; apply_stimulus(3);
    in_port = 4'hF; apply_stimulus(8);
    expect_reg(2'd0, 32'hF, "glitch_data");
    expect_reg(2'd3, 32'h0, "glitch_cap");
    in_port = 4'hD; apply_stimulus(6);
    expect_reg(2'd0, 32'hD, "hold_data");
    expect_reg(2'd3, 32'h2, "hold_cap");

    // Clear and mask
    do_reset(4'hF);
    in_port = 4'hA; apply_stimulus(6);
    in_port = 4'hF;
    expect_reg(2'd3, 32'h5, "cm_cap5");
    do_write(2'd2, 32'h4);
    check_output("cm_irq_on", {31'd0, irq}, 32'd1);
    do_write(2'd3, 32'h4);
    expect_reg(2'd3, 32'h1, "cm_cap1");
    check_output("cm_irq_off", {31'd0, irq}, 32'd0);
    do_write(2'd2, 32'h1);
    check_output("cm_irq_remask", {31'd0, irq}, 32'd1);

    // Set/clear collision on the acceptance edge
    do_reset(4'hF);
    in_port = 4'hE; apply_stimulus(5);
    do_write(2'd3, 32'h1);
    expect_reg(2'd3, 32'h1, "collide_cap");
    expect_reg(2'd0, 32'hE, "collide_data");

    // Reset in the middle of a bit 2 debounce
    do_reset(4'hF);
    in_port = 4'hB; apply_stimulus(4);
    reset_n = 1'b0;
    expect_reg(2'd3, 32'h0, "midrst_cap");
    expect_reg(2'd0, 32'hF, "midrst_data");
    apply_stimulus(2);
    reset_n = 1'b1;
    apply_stimulus(5);
    expect_reg(2'd0, 32'hF, "midrst_data_5");
    apply_stimulus(1);
    expect_reg(2'd0, 32'hB, "midrst_data_6");
    expect_reg(2'd3, 32'h4, "midrst_cap_6");

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 5) == 0) in_port = in_port ^ W'($urandom_range(1, 15));
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 7) != 0);
      writedata  = $urandom;
      reset_n    = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    apply_stimulus(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
